// File: rtl/thiele_receipt_pkg.sv
// Shared definitions for the receipt hash chain: FSM states, IV, round constants
// and the single-word mix function that the software harness reproduces.
package thiele_receipt_pkg;

   typedef enum logic [1:0] {IDLE, ABSORB, HALTED} state_t;

   localparam logic [31:0] K   = 32'h9E3779B9;
   localparam int          ROT = 5;

   // hi = FACEB00C ^ (i * K), packed with h7 in the top word
   function automatic logic [255:0] iv_init();
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[i*32 +: 32] = 32'hFACEB00C ^ (32'(i) * K);
      end
      return r;
   endfunction

   localparam logic [255:0] IV = iv_init();

   // One absorb round: rotl(hk ^ wk, ROT) + hnext + K, all mod 2^32
   function automatic logic [31:0] mix_round(logic [31:0] hk, logic [31:0] wk,
                                             logic [31:0] hnext);
      logic [31:0] t;
      t = hk ^ wk;
      return ((t << ROT) | (t >> (32 - ROT))) + hnext + K;
   endfunction

endpackage

// File: rtl/receipt_hash_chain.sv
// Folds CPU step snapshots into a 256-bit order-sensitive digest, one word per
// cycle, while accumulating a saturating mu-cost and a step count. A HALT
// snapshot freezes the receipt until clear or reset.
module receipt_hash_chain
   import thiele_receipt_pkg::*;
#(
   parameter int ROUNDS = 8,
   parameter int MU_W   = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            snap_valid,
   output logic            snap_ready,
   input  logic [31:0]     snap_pc,
   input  logic [31:0]     snap_cert_addr,
   input  logic [31:0]     snap_status,
   input  logic [31:0]     snap_error,
   input  logic [31:0]     snap_partition_ops,
   input  logic [31:0]     snap_mdl_ops,
   input  logic [31:0]     snap_info_gain,
   input  logic [31:0]     snap_mu_delta,
   input  logic            snap_halt,
   output logic            busy,
   output logic            done,
   output logic            halted,
   output logic [255:0]    digest,
   output logic [MU_W-1:0] mu_total,
   output logic [31:0]     step_count
);

   localparam int KW = $clog2(ROUNDS);

   state_t              state, state_nxt;
   logic [7:0][31:0]    h;
   logic [7:0][31:0]    w;
   logic [31:0]         delta_q;
   logic                halt_q;
   logic [KW-1:0]       k;
   logic                done_q;
   logic                last_round;
   logic [MU_W:0]       mu_sum;
   logic [MU_W-1:0]     mu_next;

   assign snap_ready = (state == IDLE);
   assign busy       = (state == ABSORB);
   assign halted     = (state == HALTED);
   assign done       = done_q;
   assign digest     = h;
   assign last_round = (state == ABSORB) && (k == KW'(ROUNDS - 1));

   // Saturating mu add: a carry out of MU_W bits pins the total at all-ones
   assign mu_sum  = {1'b0, mu_total} + {{(MU_W + 1 - 32){1'b0}}, delta_q};
   assign mu_next = mu_sum[MU_W] ? {MU_W{1'b1}} : mu_sum[MU_W-1:0];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: clear overrides everything except reset
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (snap_valid) state_nxt = ABSORB;
         ABSORB:  if (last_round) state_nxt = halt_q ? HALTED : IDLE;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   // Datapath: capture on handshake, one round per cycle, counters on the last round
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         h          <= IV;
         w          <= '0;
         delta_q    <= '0;
         halt_q     <= 1'b0;
         k          <= '0;
         done_q     <= 1'b0;
         mu_total   <= '0;
         step_count <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (snap_valid) begin
                  w       <= {step_count, snap_info_gain, snap_mdl_ops, snap_partition_ops,
                              snap_error, snap_status, snap_cert_addr, snap_pc};
                  delta_q <= snap_mu_delta;
                  halt_q  <= snap_halt;
                  k       <= '0;
               end
            end
            ABSORB: begin
               // h[k+1] is read before this edge updates it; at k=7 it wraps to the new h0
               h[k] <= mix_round(h[k], w[k], h[KW'(k + 1'b1)]);
               k    <= KW'(k + 1'b1);
               if (last_round) begin
                  step_count <= step_count + 32'd1;
                  mu_total   <= mu_next;
                  done_q     <= halt_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_receipt_hash_chain.sv
// Randomized bench for receipt_hash_chain against a word-level reference model.
module tb_receipt_hash_chain;

   localparam int MU_W = 34;
   localparam logic [63:0] MU_MAX = (64'd1 << MU_W) - 64'd1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clear = 1'b0;
   logic            snap_valid = 1'b0;
   logic            snap_ready;
   logic [31:0]     snap_pc = '0, snap_cert_addr = '0, snap_status = '0, snap_error = '0;
   logic [31:0]     snap_partition_ops = '0, snap_mdl_ops = '0, snap_info_gain = '0;
   logic [31:0]     snap_mu_delta = '0;
   logic            snap_halt = 1'b0;
   logic            busy, done, halted;
   logic [255:0]    digest;
   logic [MU_W-1:0] mu_total;
   logic [31:0]     step_count;

   receipt_hash_chain #(.ROUNDS(8), .MU_W(MU_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .snap_valid(snap_valid), .snap_ready(snap_ready),
      .snap_pc(snap_pc), .snap_cert_addr(snap_cert_addr), .snap_status(snap_status),
      .snap_error(snap_error), .snap_partition_ops(snap_partition_ops),
      .snap_mdl_ops(snap_mdl_ops), .snap_info_gain(snap_info_gain),
      .snap_mu_delta(snap_mu_delta), .snap_halt(snap_halt),
      .busy(busy), .done(done), .halted(halted),
      .digest(digest), .mu_total(mu_total), .step_count(step_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // ---------------- reference model ----------------
   logic [31:0] mh [8];
   logic [63:0] mmu;
   logic [31:0] mstep;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
      return (x << s) | (x >> (32 - s));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mh[i] = 32'hFACEB00C ^ (32'(i) * 32'h9E3779B9);
      mmu   = 64'd0;
      mstep = 32'd0;
   endtask

   // Rounds in order; earlier rounds' results are visible to later ones (h0 at round 7)
   task automatic model_absorb(input logic [6:0][31:0] ws, input logic [31:0] d);
      logic [31:0] wv [8];
      for (int i = 0; i < 7; i++) wv[i] = ws[i];
      wv[7] = mstep;
      for (int r = 0; r < 8; r++)
         mh[r] = rotl(mh[r] ^ wv[r], 5) + mh[(r + 1) % 8] + 32'h9E3779B9;
      mstep = mstep + 32'd1;
      mmu   = mmu + {32'd0, d};
      if (mmu > MU_MAX) mmu = MU_MAX;
   endtask

   function automatic logic [255:0] model_digest();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = mh[i];
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [6:0][31:0] ws, input logic [31:0] d, input logic hlt);
      snap_pc = ws[0]; snap_cert_addr = ws[1]; snap_status = ws[2]; snap_error = ws[3];
      snap_partition_ops = ws[4]; snap_mdl_ops = ws[5]; snap_info_gain = ws[6];
      snap_mu_delta = d; snap_halt = hlt;
   endtask

   function automatic logic [6:0][31:0] rnd_words();
      logic [6:0][31:0] r;
      for (int i = 0; i < 7; i++) r[i] = $urandom;
      return r;
   endfunction

   // Offer one snapshot, wait for acceptance and completion; returns ready-low cycles
   task automatic send(input logic [6:0][31:0] ws, input logic [31:0] d, input logic hlt,
                       output int lo);
      bit ok, rb;
      ok = 0; lo = 0;
      drive(ws, d, hlt);
      snap_valid = 1'b1;
      for (int t = 0; t < 40 && !ok; t++) begin
         rb = snap_ready;
         tick();
         if (rb) ok = 1;
      end
      snap_valid = 1'b0;
      if (!ok) chk("handshake_timeout", 0, 1);
      else model_absorb(ws, d);
      for (int t = 0; t < 40 && busy; t++) begin
         if (!snap_ready) lo++;
         tick();
      end
      if (busy) chk("absorb_timeout", 0, 1);
   endtask

   task automatic do_clear();
      clear = 1'b1; tick(); clear = 1'b0;
      model_reset();
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_digest"}, digest, model_digest());
      chk({tag, "_mu"}, mu_total, mmu[MU_W-1:0]);
      chk({tag, "_step"}, step_count, mstep);
   endtask

   logic [255:0] iv_exp, dig_ab, dig_ba, frozen;
   logic [6:0][31:0] wa, wb, cur;
   int lo, acc, last, rdy_hi, chg, d0;
   bit rb;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      model_reset();
      iv_exp = model_digest();
      // ---- reset and idle ----
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk_state("reset");
      chk("reset_h0", digest[31:0], 32'hFACEB00C);
      chk("reset_h1", digest[63:32], 32'h64F9C9B5);
      chk("reset_ready", snap_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_halted", halted, 0);
      chk("reset_done", done, 0);

      // ---- single all-zero snapshot ----
      send('0, 32'd7, 1'b0, lo);
      chk("zero_ready_low", lo, 8);
      chk("zero_ready_back", snap_ready, 1);
      chk_state("zero");
      chk("zero_mu7", mu_total, 7);
      chk("zero_ne_iv", digest != iv_exp, 1);

      // ---- throughput and saturation, valid held high ----
      do_clear();
      acc = 0; last = 0;
      cur = rnd_words();
      drive(cur, 32'hFFFFFFFF, 1'b0);
      snap_valid = 1'b1;
      for (int c = 0; c < 80 && acc < 5; c++) begin
         rb = snap_ready;
         tick();
         if (rb) begin
            model_absorb(cur, 32'hFFFFFFFF);
            if (acc > 0) chk("tput_spacing", c - last, 9);
            last = c;
            acc++;
            cur = rnd_words();
            drive(cur, 32'hFFFFFFFF, 1'b0);
         end
      end
      snap_valid = 1'b0;
      for (int t = 0; t < 20 && busy; t++) tick();
      chk("tput_accepted", acc, 5);
      chk_state("tput");
      chk("tput_sat", mu_total, 34'h3_FFFF_FFFF);
      chk("tput_no_done", done_cnt, 0);

      // ---- random snapshots ----
      for (int n = 0; n < 6; n++) begin
         send(rnd_words(), $urandom, 1'b0, lo);
         chk("rand_ready_low", lo, 8);
         chk_state("rand");
      end

      // ---- halt, ignore, clear ----
      d0 = done_cnt;
      send(rnd_words(), $urandom_range(0, 1000), 1'b1, lo);
      repeat (3) tick();
      chk("halt_done_pulses", done_cnt - d0, 1);
      chk("halt_halted", halted, 1);
      chk("halt_ready", snap_ready, 0);
      chk_state("halt");
      frozen = digest;
      rdy_hi = 0; chg = 0;
      drive(rnd_words(), 32'd55, 1'b0);
      snap_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (snap_ready || busy) rdy_hi++;
         if (digest !== frozen) chg++;
      end
      snap_valid = 1'b0;
      chk("halt_ignore_ready", rdy_hi, 0);
      chk("halt_ignore_digest", chg, 0);
      chk_state("halt_frozen");
      chk("halt_still", halted, 1);
      do_clear();
      chk_state("clear");
      chk("clear_halted", halted, 0);
      chk("clear_ready", snap_ready, 1);

      // ---- reset during round 3 after one completed snapshot ----
      send(rnd_words(), $urandom, 1'b0, lo);
      chk_state("pre_rst");
      drive(rnd_words(), 32'd99, 1'b0);
      snap_valid = 1'b1; tick(); snap_valid = 1'b0;  // E0
      chk("rst_accepted", busy, 1);
      repeat (3) tick();                              // E1..E3
      rst_n = 1'b0; tick(); rst_n = 1'b1;             // E4 aborts
      model_reset();
      chk_state("rst_abort");
      chk("rst_busy", busy, 0);
      chk("rst_ready", snap_ready, 1);

      // ---- clear during round 5 ----
      send(rnd_words(), $urandom, 1'b0, lo);
      drive(rnd_words(), 32'd3, 1'b0);
      snap_valid = 1'b1; tick(); snap_valid = 1'b0;
      repeat (5) tick();
      do_clear();
      chk_state("clr_abort");
      chk("clr_busy", busy, 0);
      send(rnd_words(), 32'd11, 1'b0, lo);
      chk_state("after_clr");

      // ---- order sensitivity ----
      wa = rnd_words(); wa[0] = 32'd4;
      wb = rnd_words(); wb[0] = 32'd8;
      do_clear();
      send(wa, 32'd1, 1'b0, lo);
      send(wb, 32'd2, 1'b0, lo);
      chk_state("order_ab");
      dig_ab = digest;
      do_clear();
      send(wb, 32'd2, 1'b0, lo);
      send(wa, 32'd1, 1'b0, lo);
      chk_state("order_ba");
      dig_ba = digest;
      chk("order_differs", dig_ab != dig_ba, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
